gpio_irq_ctrl: RTL



---
 rtl/gpio_irq_ctrl_pkg.sv | 30 +++
 rtl/gpio_irq_ctrl_if.sv | 21 ++
 rtl/gpio_irq_ctrl_sync.sv | 21 ++
 rtl/gpio_irq_ctrl.sv | 115 +++++++++++
 4 files changed

// File: rtl/gpio_irq_ctrl_pkg.sv
// Shared register map, interrupt encodings and byte-lane helper for the GPIO
// controller.
package gpio_pkg;

    localparam logic [3:0] GPIO_OUT        = 4'd0;
    localparam logic [3:0] GPIO_DIR        = 4'd1;
    localparam logic [3:0] GPIO_PULLEN     = 4'd2;
    localparam logic [3:0] GPIO_IN         = 4'd3;
    localparam logic [3:0] GPIO_OUT_SET    = 4'd4;
    localparam logic [3:0] GPIO_OUT_CLR    = 4'd5;
    localparam logic [3:0] GPIO_OUT_TGL    = 4'd6;
    localparam logic [3:0] GPIO_IRQ_EN     = 4'd7;
    localparam logic [3:0] GPIO_IRQ_TYPE   = 4'd8;
    localparam logic [3:0] GPIO_IRQ_POL    = 4'd9;
    localparam logic [3:0] GPIO_IRQ_STATUS = 4'd10;
    localparam logic [3:0] GPIO_INFO       = 4'd11;

    localparam logic IRQ_TYPE_LEVEL = 1'b0;
    localparam logic IRQ_TYPE_EDGE  = 1'b1;
    localparam logic IRQ_POL_LOW    = 1'b0;
    localparam logic IRQ_POL_HIGH   = 1'b1;

    // Expand 4 byte enables into a 32-bit bit mask.
    function automatic logic [31:0] sel_mask(input logic [3:0] sel);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{sel[i]}};
        return m;
    endfunction

endpackage

// File: rtl/gpio_irq_ctrl_if.sv
// Wishbone slave bus bundle for the GPIO controller.
interface gpio_irq_ctrl_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/gpio_irq_ctrl_sync.sv
// Multi-flop synchroniser for asynchronous pad inputs.
module gpio_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] stg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stg <= '0;
        else        stg <= {stg[STAGES-2:0], d};
    end

    assign q = stg[STAGES-1];

endmodule

// File: rtl/gpio_irq_ctrl.sv
// Wishbone GPIO controller: output/direction/pull registers, atomic output ops,
// synchronised inputs and per-pin level/edge interrupts with W1C status.
module gpio_irq_ctrl
    import gpio_pkg::*;
#(
    parameter int                  GPIO_NUM    = 8,
    parameter int                  SYNC_STAGES = 2,
    parameter logic [GPIO_NUM-1:0] DIR_RST     = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    gpio_irq_ctrl_if.slave      wb,
    input  logic [GPIO_NUM-1:0] gpio_in,
    output logic [GPIO_NUM-1:0] gpio_out,
    output logic [GPIO_NUM-1:0] gpio_dir,
    output logic [GPIO_NUM-1:0] gpio_pullen,
    output logic                irq_o
);

    typedef logic [GPIO_NUM-1:0] pins_t;

    pins_t       out_q, dir_q, pul_q, en_q, typ_q, pol_q, st_q, prev_q, sync_q;
    pins_t       bm, wd, w1c, ev;
    logic        hit, wr, ack_q;
    logic [3:0]  idx;
    logic [31:0] rdata, dat_q;
    logic        unused_ok;

    // Holding the strobe after the ack cannot re-trigger while ack is high.
    assign hit = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
    assign wr  = hit & wb.wb_we_i;
    assign idx = wb.wb_adr_i[5:2];
    assign bm  = GPIO_NUM'(sel_mask(wb.wb_sel_i));
    assign wd  = GPIO_NUM'(wb.wb_dat_i) & bm;
    assign w1c = (wr && idx == GPIO_IRQ_STATUS) ? wd : '0;

    assign unused_ok = ^{wb.wb_adr_i, wb.wb_dat_i};

    gpio_sync #(.WIDTH(GPIO_NUM), .STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (gpio_in),
        .q     (sync_q)
    );

    always_comb begin
        ev = '0;
        for (int i = 0; i < GPIO_NUM; i++) begin
            if (typ_q[i] == IRQ_TYPE_EDGE)
                ev[i] = (pol_q[i] == IRQ_POL_HIGH) ? (sync_q[i] & ~prev_q[i])
                                                   : (~sync_q[i] & prev_q[i]);
            else
                ev[i] = (pol_q[i] == IRQ_POL_HIGH) ? sync_q[i] : ~sync_q[i];
        end
    end

    always_comb begin
        rdata = '0;
        case (idx)
            GPIO_OUT:        rdata = 32'(out_q);
            GPIO_DIR:        rdata = 32'(dir_q);
            GPIO_PULLEN:     rdata = 32'(pul_q);
            GPIO_IN:         rdata = 32'(sync_q);
            GPIO_IRQ_EN:     rdata = 32'(en_q);
            GPIO_IRQ_TYPE:   rdata = 32'(typ_q);
            GPIO_IRQ_POL:    rdata = 32'(pol_q);
            GPIO_IRQ_STATUS: rdata = 32'(st_q);
            GPIO_INFO:       rdata = {20'd0, 4'(SYNC_STAGES), 2'd0, 6'(GPIO_NUM)};
            default:         rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            dir_q  <= DIR_RST;
            pul_q  <= '0;
            en_q   <= '0;
            typ_q  <= '0;
            pol_q  <= '0;
            st_q   <= '0;
            prev_q <= '0;
            ack_q  <= 1'b0;
            dat_q  <= '0;
        end else begin
            ack_q  <= hit;
            dat_q  <= (hit && !wb.wb_we_i) ? rdata : '0;
            prev_q <= sync_q;
            // A new event beats a simultaneous clear of the same bit.
            st_q   <= (st_q & ~w1c) | (ev & en_q);
            if (wr) begin
                case (idx)
                    GPIO_OUT:      out_q <= (out_q & ~bm) | wd;
                    GPIO_DIR:      dir_q <= (dir_q & ~bm) | wd;
                    GPIO_PULLEN:   pul_q <= (pul_q & ~bm) | wd;
                    GPIO_OUT_SET:  out_q <= out_q | wd;
                    GPIO_OUT_CLR:  out_q <= out_q & ~wd;
                    GPIO_OUT_TGL:  out_q <= out_q ^ wd;
                    GPIO_IRQ_EN:   en_q  <= (en_q & ~bm) | wd;
                    GPIO_IRQ_TYPE: typ_q <= (typ_q & ~bm) | wd;
                    GPIO_IRQ_POL:  pol_q <= (pol_q & ~bm) | wd;
                    default: ;
                endcase
            end
        end
    end

    assign gpio_out    = out_q;
    assign gpio_dir    = dir_q;
    assign gpio_pullen = pul_q;
    assign irq_o       = |st_q;
    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_q;

endmodule
